// File: rtl/nes_controller_reader.sv
// NES controller poller.
// Strobes the controller latch, clocks out the eight button bits with
// nes_pulse and presents them as a registered, active-low (0 = pressed)
// parallel word. One poll frame starts every POLL_CYC clock cycles.
module nes_controller_reader #(
    parameter int LATCH_CYC = 600,      // cycles nes_latch is held high
    parameter int HALF_CYC  = 300,      // cycles per pulse half-period (>= 4)
    parameter int POLL_CYC  = 833333    // cycles between frame starts
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       valid
);

    localparam int POLL_W    = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LATCH = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic              syncStage1;
    logic              syncStage2;
    logic [POLL_W-1:0] pollCntReg;
    logic              pollTick;

    logic [2:0]         stateReg,    stateNext;
    logic [PHASE_W-1:0] phaseCntReg, phaseCntNext;
    logic [2:0]         bitIdxReg,   bitIdxNext;
    logic [7:0]         shiftReg;
    logic [7:0]         buttonsReg;
    logic               latchReg;
    logic               pulseReg;
    logic               validReg;
    logic               captureEn;
    logic               loadButtons;

    // Two-flop synchroniser for the asynchronous controller data line;
    // idles high so a missing controller reads as "released".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            syncStage1 <= 1'b1;
            syncStage2 <= 1'b1;
        end else begin
            syncStage1 <= nes_data;
            syncStage2 <= syncStage1;
        end
    end

    // Free-running poll counter; its wrap is the frame-start tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pollCntReg <= '0;
        end else if (pollTick) begin
            pollCntReg <= '0;
        end else begin
            pollCntReg <= pollCntReg + POLL_W'(1);
        end
    end

    assign pollTick = (pollCntReg == POLL_W'(POLL_CYC - 1));

    // Frame sequencer: latch, then eight low/high half-periods with the
    // sample taken in the last cycle of each low half, then one DONE cycle.
    always_comb begin
        stateNext    = stateReg;
        phaseCntNext = phaseCntReg;
        bitIdxNext   = bitIdxReg;
        captureEn    = 1'b0;
        loadButtons  = 1'b0;
        case (stateReg)
            IDLE: begin
                phaseCntNext = '0;
                bitIdxNext   = 3'd0;
                if (pollTick) begin
                    stateNext = LATCH;
                end
            end
            LATCH: begin
                if (phaseCntReg == PHASE_W'(LATCH_CYC - 1)) begin
                    phaseCntNext = '0;
                    stateNext    = LOW;
                end else begin
                    phaseCntNext = phaseCntReg + PHASE_W'(1);
                end
            end
            LOW: begin
                if (phaseCntReg == PHASE_W'(HALF_CYC - 1)) begin
                    phaseCntNext = '0;
                    captureEn    = 1'b1;
                    stateNext    = (bitIdxReg == 3'd7) ? DONE : HIGH;
                end else begin
                    phaseCntNext = phaseCntReg + PHASE_W'(1);
                end
            end
            HIGH: begin
                if (phaseCntReg == PHASE_W'(HALF_CYC - 1)) begin
                    phaseCntNext = '0;
                    bitIdxNext   = bitIdxReg + 3'd1;
                    stateNext    = LOW;
                end else begin
                    phaseCntNext = phaseCntReg + PHASE_W'(1);
                end
            end
            DONE: begin
                loadButtons = 1'b1;
                bitIdxNext  = 3'd0;
                stateNext   = IDLE;
            end
            default: begin
                stateNext    = IDLE;
                phaseCntNext = '0;
                bitIdxNext   = 3'd0;
            end
        endcase
    end

    // Sequencer state plus glitch-free registered strobes decoded from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg    <= IDLE;
            phaseCntReg <= '0;
            bitIdxReg   <= 3'd0;
            latchReg    <= 1'b0;
            pulseReg    <= 1'b0;
            validReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            phaseCntReg <= phaseCntNext;
            bitIdxReg   <= bitIdxNext;
            latchReg    <= (stateNext == LATCH);
            pulseReg    <= (stateNext == HIGH);
            validReg    <= (stateNext == DONE);
        end
    end

    // Per-bit capture of the serial stream; only the addressed bit loads.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gen_shift
            // Bit gi takes the synchronised data in the sample cycle of its own low half.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    shiftReg[gi] <= 1'b1;
                end else if (captureEn && (bitIdxReg == 3'(gi))) begin
                    shiftReg[gi] <= syncStage2;
                end
            end
        end
    endgenerate

    // Published button word: changes only when a complete frame finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buttonsReg <= 8'hFF;
        end else if (loadButtons) begin
            buttonsReg <= shiftReg;
        end
    end

    assign nes_latch = latchReg;
    assign nes_pulse = pulseReg;
    assign valid     = validReg;
    assign buttons   = buttonsReg;
    assign up        = buttonsReg[4];
    assign down      = buttonsReg[5];
    assign left      = buttonsReg[6];
    assign right     = buttonsReg[7];

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a small NES controller model.
module tb_nes_controller_reader;

    localparam int LATCH_CYC = 4;
    localparam int HALF_CYC  = 4;
    localparam int POLL_CYC  = 100;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       nes_data = 1'b1;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       valid;

    int         totalCnt = 0;
    int         badCnt   = 0;
    int         cyc;
    int         modelIdx = 0;
    logic [7:0] pattern  = 8'hFF;

    nes_controller_reader #(
        .LATCH_CYC(LATCH_CYC),
        .HALF_CYC (HALF_CYC),
        .POLL_CYC (POLL_CYC)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .nes_data (nes_data),
        .nes_latch(nes_latch),
        .nes_pulse(nes_pulse),
        .buttons  (buttons),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .valid    (valid)
    );

    always #5 clock = ~clock;

    // Cycle count since reset release: value N after the N-th rising edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Controller model: bit 0 on latch rise, next bit on each pulse rise.
    always @(posedge nes_latch or posedge nes_pulse) begin
        if (nes_latch) modelIdx = 0;
        else if (modelIdx < 7) modelIdx = modelIdx + 1;
        nes_data = pattern[modelIdx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Waits for the next frame and checks its timing, stability and result.
    task automatic runFrame(input string name, input int expStart,
                            input logic [7:0] expNew, input logic [7:0] expOld);
        int   waitN = 0;
        int   earlyValid = 0;
        int   unstable = 0;
        int   latchCnt = 0;
        int   pulseCnt = 0;
        int   badHigh = 0;
        int   badGap = 0;
        int   overlap = 0;
        int   highRun = 0;
        int   gapRun = 0;
        int   guard = 0;
        logic prevPulse = 1'b0;
        while (nes_latch !== 1'b1 && waitN < 300) begin
            if (valid === 1'b1) earlyValid++;
            if (buttons !== expOld) unstable++;
            @(negedge clock);
            waitN++;
        end
        check({name, "_latch_seen"}, 32'(nes_latch), 32'd1);
        check({name, "_latch_start"}, 32'(cyc), 32'(expStart));
        check({name, "_no_early_valid"}, 32'(earlyValid), 32'd0);
        while (valid !== 1'b1 && guard < 100) begin
            if (nes_latch) latchCnt++;
            if (nes_latch && nes_pulse) overlap++;
            if (buttons !== expOld) unstable++;
            if (nes_pulse) begin
                if (!prevPulse) begin
                    pulseCnt++;
                    if (gapRun != HALF_CYC) badGap++;
                    gapRun = 0;
                end
                highRun++;
            end else begin
                if (prevPulse) begin
                    if (highRun != HALF_CYC) badHigh++;
                    highRun = 0;
                end
                if (!nes_latch) gapRun++;
            end
            prevPulse = nes_pulse;
            @(negedge clock);
            guard++;
        end
        check({name, "_valid_seen"}, 32'(valid), 32'd1);
        check({name, "_valid_cycle"}, 32'(cyc), 32'(expStart + 64));
        check({name, "_latch_width"}, 32'(latchCnt), 32'd4);
        check({name, "_pulse_count"}, 32'(pulseCnt), 32'd7);
        check({name, "_bad_high_widths"}, 32'(badHigh), 32'd0);
        check({name, "_bad_low_widths"}, 32'(badGap), 32'd0);
        check({name, "_latch_pulse_overlap"}, 32'(overlap), 32'd0);
        check({name, "_buttons_held"}, 32'(unstable), 32'd0);
        @(negedge clock);
        check({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
        check({name, "_buttons"}, 32'(buttons), 32'(expNew));
        check({name, "_dirs"}, {28'd0, right, left, down, up}, {28'd0, expNew[7:4]});
    endtask

    initial begin
        int n;
        int rises;
        int rstValid;
        logic prev;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_buttons", 32'(buttons), 32'hFF);
        check("rst_dirs", {28'd0, right, left, down, up}, 32'hF);
        check("rst_strobes", {29'd0, nes_latch, nes_pulse, valid}, 32'd0);

        // Data capture: A..Right = 0,1,1,1,1,0,1,1 -> 8'hDE
        pattern = 8'hDE;
        reset_n = 1'b1;
        runFrame("f1", 100, 8'hDE, 8'hFF);
        runFrame("f2", 200, 8'hDE, 8'hDE);

        // All released, buttons held at the old value until the frame ends
        pattern = 8'hFF;
        runFrame("f3", 300, 8'hFF, 8'hDE);
        runFrame("f4", 400, 8'hFF, 8'hFF);

        // A different pattern between frames
        pattern = 8'h5A;
        runFrame("f5", 500, 8'h5A, 8'hFF);

        // Reset during the 3rd pulse of a frame pressing Right
        pattern = 8'h7F;
        n = 0;
        while (nes_latch !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        rises = 0;
        prev  = 1'b0;
        while (rises < 3 && n < 400) begin
            @(negedge clock);
            n++;
            if (nes_pulse && !prev) rises++;
            prev = nes_pulse;
        end
        check("mid_third_pulse_seen", 32'(rises), 32'd3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_strobes", {29'd0, nes_latch, nes_pulse, valid}, 32'd0);
        check("mid_rst_buttons", 32'(buttons), 32'hFF);
        rstValid = 0;
        repeat (3) begin
            @(negedge clock);
            if (valid !== 1'b0) rstValid++;
        end
        check("mid_rst_no_valid", 32'(rstValid), 32'd0);
        reset_n = 1'b1;
        runFrame("after_rst", 100, 8'h7F, 8'hFF);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
